// File: rtl/l1_trig_pkg.sv
// Shared definitions for the L1 trigger Wishbone interconnect.
//   space_e  : subspace selected by the top two address bits
//   state_e  : router FSM states
//   rsp_e    : upstream response kind
//   req_t    : latched request fields forwarded downstream
//   resolve_rsp() : folds simultaneous slave responses, err > rty > ack
package l1_trig_pkg;

   localparam int ADR_W      = 15;
   localparam int SPACE_MSB  = 14;
   localparam int SPACE_LSB  = 13;
   localparam int LOCAL_W    = 13;
   localparam int SEL_W      = 4;
   localparam int NUM_SPACES = 4;

   typedef enum logic [1:0] {
      SP_THRESH  = 2'd0,
      SP_CONTROL = 2'd1,
      SP_AGC     = 2'd2,
      SP_BQ      = 2'd3
   } space_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      RSP_ACK = 2'd0,
      RSP_ERR = 2'd1,
      RSP_RTY = 2'd2
   } rsp_e;

   typedef struct packed {
      logic               we;
      logic [LOCAL_W-1:0] adr;
      logic [SEL_W-1:0]   sel;
   } req_t;

   // Only called once some response bit is known to be set, so the
   // fall-through case is an ack.
   function automatic rsp_e resolve_rsp(input logic err, input logic rty);
      if (err)      return RSP_ERR;
      else if (rty) return RSP_RTY;
      else          return RSP_ACK;
   endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Cycle counter bounding how long the router waits on a downstream slave.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (held while not waiting)
//   en         : count enable
//   expired    : high on the TIMEOUT-th enabled cycle; never for TIMEOUT=0
module wb_timeout_counter #(
   parameter int TIMEOUT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               cnt_q <= '0;
      else if (clr)             cnt_q <= '0;
      else if (en && !expired)  cnt_q <= cnt_q + 1'b1;
   end

   // Counter holds 0 on the first waiting cycle, so matching TIMEOUT-1
   // flags the TIMEOUT-th one.
   assign expired = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/l1_trigger_intercon.sv
// Wishbone 1-to-4 router for the L1 trigger register space.
//   wb_*       : upstream slave port (15-bit address, classic cycles)
//   clock_enabled_i : high when the gated subspaces are clocked
//   thresh_/control_/agc_/bq_ *_o : downstream master ports (13-bit address)
//   thresh_/control_/agc_/bq_ *_i : downstream responses and read data
// One access in flight. Accesses to a gated subspace whose clock is off
// are answered locally with GATED_RDATA; a silent slave is answered with
// err after TIMEOUT cycles, so the upstream bus can never hang.
module l1_trigger_intercon
   import l1_trig_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [NUM_SPACES-1:0] GATED_MASK  = 4'b0011,
   parameter int                    TIMEOUT     = 256,
   parameter logic [DATA_WIDTH-1:0] GATED_RDATA = '0
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_ni,
   input  logic                  clock_enabled_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [ADR_W-1:0]      wb_adr_i,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   input  logic [SEL_W-1:0]      wb_sel_i,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
   output logic                  wb_rty_o,
   output logic [DATA_WIDTH-1:0] wb_dat_o,

   output logic                  thresh_cyc_o,
   output logic                  thresh_stb_o,
   output logic                  thresh_we_o,
   output logic [LOCAL_W-1:0]    thresh_adr_o,
   output logic [DATA_WIDTH-1:0] thresh_dat_o,
   output logic [SEL_W-1:0]      thresh_sel_o,
   input  logic                  thresh_ack_i,
   input  logic                  thresh_err_i,
   input  logic                  thresh_rty_i,
   input  logic [DATA_WIDTH-1:0] thresh_dat_i,

   output logic                  control_cyc_o,
   output logic                  control_stb_o,
   output logic                  control_we_o,
   output logic [LOCAL_W-1:0]    control_adr_o,
   output logic [DATA_WIDTH-1:0] control_dat_o,
   output logic [SEL_W-1:0]      control_sel_o,
   input  logic                  control_ack_i,
   input  logic                  control_err_i,
   input  logic                  control_rty_i,
   input  logic [DATA_WIDTH-1:0] control_dat_i,

   output logic                  agc_cyc_o,
   output logic                  agc_stb_o,
   output logic                  agc_we_o,
   output logic [LOCAL_W-1:0]    agc_adr_o,
   output logic [DATA_WIDTH-1:0] agc_dat_o,
   output logic [SEL_W-1:0]      agc_sel_o,
   input  logic                  agc_ack_i,
   input  logic                  agc_err_i,
   input  logic                  agc_rty_i,
   input  logic [DATA_WIDTH-1:0] agc_dat_i,

   output logic                  bq_cyc_o,
   output logic                  bq_stb_o,
   output logic                  bq_we_o,
   output logic [LOCAL_W-1:0]    bq_adr_o,
   output logic [DATA_WIDTH-1:0] bq_dat_o,
   output logic [SEL_W-1:0]      bq_sel_o,
   input  logic                  bq_ack_i,
   input  logic                  bq_err_i,
   input  logic                  bq_rty_i,
   input  logic [DATA_WIDTH-1:0] bq_dat_i
);

   // Downstream responses gathered into vectors indexed by space_e.
   logic [NUM_SPACES-1:0]                 s_ack, s_err, s_rty;
   logic [NUM_SPACES-1:0][DATA_WIDTH-1:0] s_dat;

   assign s_ack = {bq_ack_i, agc_ack_i, control_ack_i, thresh_ack_i};
   assign s_err = {bq_err_i, agc_err_i, control_err_i, thresh_err_i};
   assign s_rty = {bq_rty_i, agc_rty_i, control_rty_i, thresh_rty_i};
   assign s_dat = {bq_dat_i, agc_dat_i, control_dat_i, thresh_dat_i};

   state_e                state_q, state_d;
   space_e                space_q;
   req_t                  req_q;
   logic [DATA_WIDTH-1:0] wdat_q;
   logic [NUM_SPACES-1:0] mst_q;   // one-hot cyc/stb of the active master
   logic                  ack_q, err_q, rty_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   space_e space_in;
   logic   blocked, hit, tmo_expired;
   logic   accept, abort, take_rsp, take_tmo;

   assign space_in = space_e'(wb_adr_i[SPACE_MSB:SPACE_LSB]);
   assign blocked  = GATED_MASK[space_in] & ~clock_enabled_i;
   assign hit      = s_ack[space_q] | s_err[space_q] | s_rty[space_q];

   wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_ni),
      .clr     (state_q != ST_BUSY),
      .en      (state_q == ST_BUSY),
      .expired (tmo_expired)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   // Abort outranks a same-cycle slave response: the master has gone away
   // and must not see a stray ack.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      abort    = 1'b0;
      take_rsp = 1'b0;
      take_tmo = 1'b0;
      case (state_q)
         ST_IDLE: if (wb_cyc_i && wb_stb_i) begin
            accept  = 1'b1;
            state_d = blocked ? ST_DONE : ST_BUSY;
         end
         ST_BUSY: if (!wb_cyc_i) begin
            abort   = 1'b1;
            state_d = ST_IDLE;
         end else if (hit) begin
            take_rsp = 1'b1;
            state_d  = ST_DONE;
         end else if (tmo_expired) begin
            take_tmo = 1'b1;
            state_d  = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Response flags are set on the edge entering DONE and cleared on every
   // other edge, which makes them single-cycle pulses aligned with DONE.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         space_q <= SP_THRESH;
         req_q   <= '0;
         wdat_q  <= '0;
         mst_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rty_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         rty_q <= 1'b0;
         if (accept) begin
            space_q <= space_in;
            req_q   <= '{we: wb_we_i, adr: wb_adr_i[LOCAL_W-1:0], sel: wb_sel_i};
            wdat_q  <= wb_dat_i;
            if (blocked) begin
               ack_q   <= 1'b1;
               rdata_q <= GATED_RDATA;
            end else begin
               mst_q           <= '0;
               mst_q[space_in] <= 1'b1;
            end
         end
         if (abort) mst_q <= '0;
         if (take_rsp) begin
            mst_q   <= '0;
            rdata_q <= s_dat[space_q];
            case (resolve_rsp(s_err[space_q], s_rty[space_q]))
               RSP_ERR: err_q <= 1'b1;
               RSP_RTY: rty_q <= 1'b1;
               default: ack_q <= 1'b1;
            endcase
         end
         if (take_tmo) begin
            mst_q   <= '0;
            err_q   <= 1'b1;
            rdata_q <= '0;
         end
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_rty_o = rty_q;
   assign wb_dat_o = rdata_q;

   // Request fields fan out to every master; only cyc/stb is steered.
   assign thresh_cyc_o  = mst_q[SP_THRESH];
   assign thresh_stb_o  = mst_q[SP_THRESH];
   assign thresh_we_o   = req_q.we;
   assign thresh_adr_o  = req_q.adr;
   assign thresh_dat_o  = wdat_q;
   assign thresh_sel_o  = req_q.sel;

   assign control_cyc_o = mst_q[SP_CONTROL];
   assign control_stb_o = mst_q[SP_CONTROL];
   assign control_we_o  = req_q.we;
   assign control_adr_o = req_q.adr;
   assign control_dat_o = wdat_q;
   assign control_sel_o = req_q.sel;

   assign agc_cyc_o     = mst_q[SP_AGC];
   assign agc_stb_o     = mst_q[SP_AGC];
   assign agc_we_o      = req_q.we;
   assign agc_adr_o     = req_q.adr;
   assign agc_dat_o     = wdat_q;
   assign agc_sel_o     = req_q.sel;

   assign bq_cyc_o      = mst_q[SP_BQ];
   assign bq_stb_o      = mst_q[SP_BQ];
   assign bq_we_o       = req_q.we;
   assign bq_adr_o      = req_q.adr;
   assign bq_dat_o      = wdat_q;
   assign bq_sel_o      = req_q.sel;

endmodule

// File: tb/tb_l1_trigger_intercon.sv
// Directed bench for l1_trigger_intercon. Downstream slaves answer
// combinationally (resp_i = stb_o & enable) with fixed read data.
module tb_l1_trigger_intercon;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [14:0] adr = '0;
   logic [31:0] wdat = '0;
   logic [3:0]  bsel = '0;
   logic        ack, err, rty;
   logic [31:0] rdat;

   logic        t_cyc, t_stb, t_we, c_cyc, c_stb, c_we, a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
   logic [12:0] t_adr, c_adr, a_adr, b_adr;
   logic [31:0] t_dat, c_dat, a_dat, b_dat;
   logic [3:0]  t_sel, c_sel, a_sel, b_sel;

   logic [3:0]  ack_en = '0, err_en = '0, rty_en = '0;
   logic [31:0] s_rdata [4];

   always #5 clk = ~clk;

   l1_trigger_intercon dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .clock_enabled_i(cen),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
      .wb_dat_i(wdat), .wb_sel_i(bsel),
      .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_dat_o(rdat),
      .thresh_cyc_o(t_cyc), .thresh_stb_o(t_stb), .thresh_we_o(t_we), .thresh_adr_o(t_adr),
      .thresh_dat_o(t_dat), .thresh_sel_o(t_sel),
      .thresh_ack_i(t_stb & ack_en[0]), .thresh_err_i(t_stb & err_en[0]),
      .thresh_rty_i(t_stb & rty_en[0]), .thresh_dat_i(s_rdata[0]),
      .control_cyc_o(c_cyc), .control_stb_o(c_stb), .control_we_o(c_we), .control_adr_o(c_adr),
      .control_dat_o(c_dat), .control_sel_o(c_sel),
      .control_ack_i(c_stb & ack_en[1]), .control_err_i(c_stb & err_en[1]),
      .control_rty_i(c_stb & rty_en[1]), .control_dat_i(s_rdata[1]),
      .agc_cyc_o(a_cyc), .agc_stb_o(a_stb), .agc_we_o(a_we), .agc_adr_o(a_adr),
      .agc_dat_o(a_dat), .agc_sel_o(a_sel),
      .agc_ack_i(a_stb & ack_en[2]), .agc_err_i(a_stb & err_en[2]),
      .agc_rty_i(a_stb & rty_en[2]), .agc_dat_i(s_rdata[2]),
      .bq_cyc_o(b_cyc), .bq_stb_o(b_stb), .bq_we_o(b_we), .bq_adr_o(b_adr),
      .bq_dat_o(b_dat), .bq_sel_o(b_sel),
      .bq_ack_i(b_stb & ack_en[3]), .bq_err_i(b_stb & err_en[3]),
      .bq_rty_i(b_stb & rty_en[3]), .bq_dat_i(s_rdata[3])
   );

   wire [3:0] dn_cyc = {b_cyc, a_cyc, c_cyc, t_cyc};
   wire [3:0] dn_stb = {b_stb, a_stb, c_stb, t_stb};

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Results of the last access() call.
   logic [2:0]  r_rsp;          // {ack,err,rty} at the response cycle
   logic [2:0]  r_after;        // same, one cycle later
   logic [31:0] r_dat;
   int          r_k;            // negedges after the strobe cycle, -1 if none
   logic [3:0]  stb_seen, snap_cyc, r_dn_at_rsp;
   logic [12:0] snap_adr [4];
   logic        snap_we;
   logic [31:0] snap_dat;

   task automatic access(input logic [14:0] a, input logic w, input logic [31:0] d, input int limit);
      bit done = 0;
      int k = 0;
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = w; adr = a; wdat = d; bsel = 4'hF;
      stb_seen = '0; snap_cyc = '0; r_k = -1; r_rsp = '0; r_dat = '0; r_dn_at_rsp = '0;
      while (!done && k <= limit) begin
         @(negedge clk);
         stb_seen |= dn_stb;
         if (k == 1) begin
            snap_cyc = dn_cyc;
            snap_adr[0] = t_adr; snap_adr[1] = c_adr; snap_adr[2] = a_adr; snap_adr[3] = b_adr;
            snap_we = c_we; snap_dat = c_dat;
         end
         if (ack | err | rty) begin
            r_rsp = {ack, err, rty}; r_dat = rdat; r_k = k; r_dn_at_rsp = dn_cyc; done = 1;
         end else k++;
      end
      @(posedge clk); #1;
      cyc = 0; stb = 0; we = 0;
      @(negedge clk);
      r_after = {ack, err, rty};
      stb_seen |= dn_stb;
   endtask

   initial begin
      bit [2:0] rsp_acc;
      s_rdata[0] = 32'h7E57_0000;
      s_rdata[1] = 32'hC0DE_0001;
      s_rdata[2] = 32'h0A6C_0008;
      s_rdata[3] = 32'hCAFE_F00D;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_rsp", {ack, err, rty}, 3'b000);
      chk("rst_dn_cyc", {dn_cyc, dn_stb}, 8'h00);
      chk("rst_dat", rdat, 32'h0);
      rst_n = 1'b1;

      // Write to control space
      ack_en = 4'b0010;
      access(15'h2010, 1'b1, 32'h1234_ABCD, 10);
      chk("wr_rsp", r_rsp, 3'b100);
      chk("wr_latency", 64'(r_k), 64'd2);
      chk("wr_cyc", snap_cyc, 4'b0010);
      chk("wr_adr", snap_adr[1], 13'h0010);
      chk("wr_we", snap_we, 1'b1);
      chk("wr_dat", snap_dat, 32'h1234_ABCD);
      chk("wr_only_ctrl", stb_seen, 4'b0010);
      chk("wr_pulse", r_after, 3'b000);

      // Read from bq
      ack_en = 4'b1000;
      access(15'h6004, 1'b0, 32'h0, 10);
      chk("bq_rsp", r_rsp, 3'b100);
      chk("bq_dat", r_dat, 32'hCAFE_F00D);
      chk("bq_adr", snap_adr[3], 13'h0004);
      chk("bq_cyc", snap_cyc, 4'b1000);

      // Gated thresh read with clock off
      cen = 1'b0;
      ack_en = 4'b0001;
      access(15'h0100, 1'b0, 32'h0, 10);
      chk("gate_rsp", r_rsp, 3'b100);
      chk("gate_latency", 64'(r_k), 64'd1);
      chk("gate_dat", r_dat, 32'h0);
      chk("gate_no_stb", stb_seen, 4'b0000);

      // Ungated agc with clock off
      ack_en = 4'b0100;
      access(15'h4008, 1'b0, 32'h0, 10);
      chk("agc_rsp", r_rsp, 3'b100);
      chk("agc_dat", r_dat, 32'h0A6C_0008);
      chk("agc_adr", snap_adr[2], 13'h0008);
      chk("agc_stb", stb_seen, 4'b0100);

      // Silent slave -> timeout err
      cen = 1'b1;
      ack_en = 4'b0000;
      access(15'h2000, 1'b0, 32'h0, 300);
      chk("tmo_rsp", r_rsp, 3'b010);
      chk("tmo_latency", 64'(r_k), 64'd257);
      chk("tmo_dat", r_dat, 32'h0);
      chk("tmo_busy_cyc", snap_cyc, 4'b0010);
      chk("tmo_dn_drop", r_dn_at_rsp, 4'b0000);
      chk("tmo_pulse", r_after, 3'b000);

      // err and ack together -> err only; rty and ack -> rty only
      ack_en = 4'b1100; err_en = 4'b1000; rty_en = 4'b0100;
      access(15'h7FFC, 1'b0, 32'h0, 10);
      chk("prio_err", r_rsp, 3'b010);
      chk("prio_err_dat", r_dat, 32'hCAFE_F00D);
      access(15'h5FFF, 1'b0, 32'h0, 10);
      chk("prio_rty", r_rsp, 3'b001);
      chk("prio_rty_adr", snap_adr[2], 13'h1FFF);
      ack_en = '0; err_en = '0; rty_en = '0;

      // Asynchronous reset mid-BUSY
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 0; adr = 15'h2004;
      @(negedge clk);
      @(negedge clk);
      chk("arst_busy", dn_cyc, 4'b0010);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_dn", {dn_cyc, dn_stb}, 8'h00);
      chk("arst_rsp", {ack, err, rty}, 3'b000);
      chk("arst_dat", rdat, 32'h0);
      cyc = 0; stb = 0;
      @(negedge clk);
      rst_n = 1'b1;
      ack_en = 4'b0001;
      access(15'h0000, 1'b0, 32'h0, 10);
      chk("post_rst_rsp", r_rsp, 3'b100);
      chk("post_rst_dat", r_dat, 32'h7E57_0000);
      chk("post_rst_latency", 64'(r_k), 64'd2);

      // Upstream abort in BUSY
      ack_en = 4'b0000;
      rsp_acc = '0;
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 0; adr = 15'h2020;
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy", dn_cyc, 4'b0010);
      @(posedge clk); #1;
      cyc = 0; stb = 0;
      @(negedge clk);
      rsp_acc |= {ack, err, rty};
      chk("abort_hold", dn_cyc, 4'b0010);
      @(negedge clk);
      rsp_acc |= {ack, err, rty};
      chk("abort_drop", {dn_cyc, dn_stb}, 8'h00);
      repeat (4) begin
         @(negedge clk);
         rsp_acc |= {ack, err, rty};
      end
      chk("abort_no_rsp", rsp_acc, 3'b000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

endmodule
